// File: rtl/pipeline_stall_control_if.sv
// Hazard/stall unit pipeline-side signals.
// Master drives the latch contents and multdiv status; slave returns the stall/sequencing controls.
interface pipeline_stall_control_if;
  logic [31:0] FD_IR;
  logic [31:0] DX_IR;
  logic        branch_taken;
  logic        data_resultRDY;
  logic        data_exception;
  logic        stall_F;
  logic        stall_D;
  logic        bubble_DX;
  logic        bubble_XM;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        md_busy;
  logic        md_done;
  logic        md_exception;
  logic        md_timeout;

  modport master (
    output FD_IR, DX_IR, branch_taken, data_resultRDY, data_exception,
    input  stall_F, stall_D, bubble_DX, bubble_XM, ctrl_MULT, ctrl_DIV,
           md_busy, md_done, md_exception, md_timeout
  );

  modport slave (
    input  FD_IR, DX_IR, branch_taken, data_resultRDY, data_exception,
    output stall_F, stall_D, bubble_DX, bubble_XM, ctrl_MULT, ctrl_DIV,
           md_busy, md_done, md_exception, md_timeout
  );
endinterface

// File: rtl/pipeline_stall_control.sv
// Load-use bubble insertion and multdiv start/wait/timeout sequencing for the 5-stage pipeline.
// state | meaning:  IDLE | normal flow, may start multdiv;  WAIT | op running, pipe frozen;  DONE | op leaves DX
module pipeline_stall_control #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  pipeline_stall_control_if.slave       bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_exc_q, md_exc_d;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       fd_uses_rt, fd_uses_rd;
  logic       dx_is_mul, dx_is_div, load_use;

  logic stall_f, stall_d, bubble_dx, bubble_xm;
  logic ctrl_mult, ctrl_div, md_busy, md_done, md_timeout;

  logic unused_ir_bits;
  assign unused_ir_bits = ^{bus.FD_IR[11:0], bus.DX_IR[21:7], bus.DX_IR[1:0]};

  assign fd_op  = bus.FD_IR[31:27];
  assign fd_rd  = bus.FD_IR[26:22];
  assign fd_rs  = bus.FD_IR[21:17];
  assign fd_rt  = bus.FD_IR[16:12];
  assign dx_op  = bus.DX_IR[31:27];
  assign dx_rd  = bus.DX_IR[26:22];
  assign dx_alu = bus.DX_IR[6:2];

  // Stores, branches and jr read rd as a source operand.
  assign fd_uses_rt = (fd_op == OP_RTYPE);
  assign fd_uses_rd = (fd_op == 5'b00111) || (fd_op == 5'b00010) ||
                      (fd_op == 5'b00110) || (fd_op == 5'b00100);

  assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_is_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);

  assign load_use = (dx_op == OP_LOAD) && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs) ||
                     (fd_uses_rt && (dx_rd == fd_rt)) ||
                     (fd_uses_rd && (dx_rd == fd_rd)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      md_exc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_exc_q <= md_exc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_exc_d   = md_exc_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    bubble_dx  = 1'b0;
    bubble_xm  = 1'b0;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    md_busy    = 1'b0;
    md_done    = 1'b0;
    md_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.branch_taken && (dx_is_mul || dx_is_div)) begin
          ctrl_mult = dx_is_mul;
          ctrl_div  = dx_is_div;
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          bubble_xm = 1'b1;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end else if (!bus.branch_taken && load_use) begin
          stall_f   = 1'b1;
          bubble_dx = 1'b1;
        end
      end
      ST_WAIT: begin
        md_busy   = 1'b1;
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        bubble_xm = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        // A result arriving on the last allowed cycle still counts as completion.
        if (bus.data_resultRDY) begin
          md_exc_d = bus.data_exception;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          md_timeout = 1'b1;
          md_exc_d   = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        md_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so a multdiv still sitting in DX cannot pulse.
  assign bus.stall_F      = stall_f    & ~reset;
  assign bus.stall_D      = stall_d    & ~reset;
  assign bus.bubble_DX    = bubble_dx  & ~reset;
  assign bus.bubble_XM    = bubble_xm  & ~reset;
  assign bus.ctrl_MULT    = ctrl_mult  & ~reset;
  assign bus.ctrl_DIV     = ctrl_div   & ~reset;
  assign bus.md_busy      = md_busy    & ~reset;
  assign bus.md_done      = md_done    & ~reset;
  assign bus.md_timeout   = md_timeout & ~reset;
  assign bus.md_exception = md_exc_q;

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Directed-vector bench for the hazard/stall unit: load-use cases and multdiv sequencing.
module tb_pipeline_stall_control;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  logic exp_exc;

  pipeline_stall_control_if bus ();

  pipeline_stall_control #(.MD_TIMEOUT(64), .CNT_W(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {stall_F, stall_D, bubble_DX, bubble_XM, ctrl_MULT, ctrl_DIV, md_busy, md_done, md_exception, md_timeout}
  localparam logic [9:0] O_IDLE = 10'b0000000000;
  localparam logic [9:0] O_LU   = 10'b1010000000;
  localparam logic [9:0] O_SMUL = 10'b1101100000;
  localparam logic [9:0] O_SDIV = 10'b1101010000;
  localparam logic [9:0] O_WAIT = 10'b1101001000;
  localparam logic [9:0] O_DONE = 10'b0000000100;
  localparam logic [9:0] O_EXC  = 10'b0000000010;
  localparam logic [9:0] O_TO   = 10'b0000000001;

  function automatic logic [9:0] outs();
    return {bus.stall_F, bus.stall_D, bus.bubble_DX, bus.bubble_XM, bus.ctrl_MULT,
            bus.ctrl_DIV, bus.md_busy, bus.md_done, bus.md_exception, bus.md_timeout};
  endfunction

  function automatic logic [31:0] instr(input logic [4:0] op, rd, rs, rt, alu);
    return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [9:0] exc_bit();
    return exp_exc ? O_EXC : O_IDLE;
  endfunction

  task automatic drive(input logic [31:0] dx, fd, input logic br, rdy, exc);
    @(negedge clock);
    bus.DX_IR          = dx;
    bus.FD_IR          = fd;
    bus.branch_taken   = br;
    bus.data_resultRDY = rdy;
    bus.data_exception = exc;
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    reset = 1'b1;
    bus.DX_IR = '0; bus.FD_IR = '0; bus.branch_taken = 1'b0;
    bus.data_resultRDY = 1'b0; bus.data_exception = 1'b0;
    exp_exc = 1'b0;
    #12;
    exp = O_IDLE;
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", outs(), exp);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    logic [31:0] dx_v [7];
    logic [31:0] fd_v [7];
    logic        br_v [7];
    logic [9:0]  ex_v [7];
    // add r1,r5,r2 behind lw r5; then the bubble leaves DX
    dx_v[0] = instr(5'b01000, 5, 1, 0, 0); fd_v[0] = instr(5'b00000, 1, 5, 2, 0); br_v[0] = 0; ex_v[0] = O_LU;
    dx_v[1] = 32'd0;                       fd_v[1] = instr(5'b00000, 1, 5, 2, 0); br_v[1] = 0; ex_v[1] = O_IDLE;
    // lw r0 never stalls
    dx_v[2] = instr(5'b01000, 0, 1, 0, 0); fd_v[2] = instr(5'b00000, 1, 0, 0, 0); br_v[2] = 0; ex_v[2] = O_IDLE;
    // sw r5 reads rd
    dx_v[3] = instr(5'b01000, 5, 1, 0, 0); fd_v[3] = instr(5'b00111, 5, 3, 0, 0); br_v[3] = 0; ex_v[3] = O_LU;
    // rt match on an R-type
    dx_v[4] = instr(5'b01000, 5, 1, 0, 0); fd_v[4] = instr(5'b00000, 1, 2, 5, 0); br_v[4] = 0; ex_v[4] = O_LU;
    // rt/rd fields of addi are not sources
    dx_v[5] = instr(5'b01000, 5, 1, 0, 0); fd_v[5] = instr(5'b00101, 5, 3, 5, 0); br_v[5] = 0; ex_v[5] = O_IDLE;
    // branch squash suppresses the stall
    dx_v[6] = instr(5'b01000, 5, 1, 0, 0); fd_v[6] = instr(5'b00000, 1, 5, 2, 0); br_v[6] = 1; ex_v[6] = O_IDLE;
    for (int i = 0; i < 7; i++) begin
      drive(dx_v[i], fd_v[i], br_v[i], 1'b0, 1'b0);
      vectors++;
      if (outs() !== ex_v[i]) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got %b want %b", i, outs(), ex_v[i]);
      end
    end
  endtask

  // Starts an op, runs n_wait WAIT cycles with RDY on the last (if rdy_last), then DONE and IDLE.
  task automatic run_op(input string name, input logic is_div, input int n_wait,
                        input logic rdy_last, input logic exc_in);
    logic [31:0] op;
    logic [9:0]  exp;
    logic        to;
    op = instr(5'b00000, 3, 1, 2, is_div ? 5'b00111 : 5'b00110);
    drive(op, 32'd0, 1'b0, 1'b0, 1'b0);
    exp = (is_div ? O_SDIV : O_SMUL) | exc_bit();
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL %s_start: got %b want %b", name, outs(), exp);
    end
    for (int i = 1; i <= n_wait; i++) begin
      drive(op, 32'd0, 1'b0, rdy_last && (i == n_wait), exc_in);
      to  = !rdy_last && (i == 64);
      exp = O_WAIT | exc_bit() | (to ? O_TO : O_IDLE);
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL %s_wait[%0d]: got %b want %b", name, i, outs(), exp);
      end
    end
    exp_exc = rdy_last ? exc_in : 1'b1;
    drive(op, 32'd0, 1'b0, 1'b0, 1'b0);
    exp = O_DONE | exc_bit();
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL %s_done: got %b want %b", name, outs(), exp);
    end
  endtask

  task automatic idle_check(input string name);
    logic [9:0] exp;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    exp = exc_bit();
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL %s_idle: got %b want %b", name, outs(), exp);
    end
  endtask

  task automatic test_mul();
    run_op("mul", 1'b0, 10, 1'b1, 1'b0);
    idle_check("mul");
  endtask

  task automatic test_div_exception();
    run_op("div", 1'b1, 3, 1'b1, 1'b1);
    idle_check("div");
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mul", 1'b0, 1, 1'b1, 1'b0);
    run_op("b2b_div", 1'b1, 2, 1'b1, 1'b0);
    idle_check("b2b");
  endtask

  task automatic test_rdy_at_limit();
    run_op("limit", 1'b0, 64, 1'b1, 1'b0);
    idle_check("limit");
  endtask

  task automatic test_timeout();
    run_op("timeout", 1'b0, 64, 1'b0, 1'b0);
    idle_check("timeout");
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] op;
    logic [9:0]  exp;
    op = instr(5'b00000, 3, 1, 2, 5'b00110);
    drive(op, 32'd0, 1'b0, 1'b0, 1'b0);
    exp = O_SMUL | exc_bit();
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL rst_wait_start: got %b want %b", outs(), exp);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(op, 32'd0, 1'b0, 1'b0, 1'b0);
      exp = O_WAIT | exc_bit();
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL rst_wait[%0d]: got %b want %b", i, outs(), exp);
      end
    end
    #1;
    reset = 1'b1;
    bus.DX_IR = 32'd0;
    exp_exc = 1'b0;
    #1;
    vectors++;
    if (outs() !== O_IDLE) begin
      miscompares++;
      $display("FAIL rst_async: got %b want %b", outs(), O_IDLE);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++;
    if (outs() !== O_IDLE) begin
      miscompares++;
      $display("FAIL rst_release: got %b want %b", outs(), O_IDLE);
    end
    idle_check("rst_after");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_load_use();
    test_mul();
    test_div_exception();
    test_back_to_back();
    test_rdy_at_limit();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
